// File: rtl/wdec_pkg.sv
// Shared definitions for the wdecoder escape-coded pixel stream decoder.
package wdec_pkg;

   typedef enum logic [2:0] {
      ST_HUNT   = 3'd0,
      ST_DATA   = 3'd1,
      ST_ESC    = 3'd2,
      ST_RUNLEN = 3'd3,
      ST_REPEAT = 3'd4
   } wdec_state_e;

   localparam logic [7:0] CODE_LIT_ESC = 8'h00;
   localparam logic [7:0] CODE_FRAME   = 8'h01;
   localparam logic [7:0] CODE_LINE    = 8'h02;
   localparam logic [7:0] CODE_RUN     = 8'h03;

endpackage

// File: rtl/wdec_run_ctr.sv
// Repeat-count down-counter for run-length tokens; only built when WDEC_RLE_EN is defined.
`ifdef WDEC_RLE_EN
module wdec_run_ctr (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       dec_i,
   output logic       done_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != 8'd0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Asserted while the final repeat of the run is being emitted.
   assign done_o = (cnt_q <= 8'd1);

endmodule
`endif

// File: rtl/wdecoder.sv
// Escape-coded pixel stream decoder with frame/line sync and pixel position tracking.
// Optional run-length repeat tokens are enabled by defining WDEC_RLE_EN.
module wdecoder
   import wdec_pkg::*;
#(
   parameter logic [7:0] ESC_CODE = 8'hFF,
   parameter int         CNT_W    = 8
) (
   input  logic             dclk,
   input  logic             rst,
   input  logic [7:0]       din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [7:0]       dout,
   output logic             pvalid,
   output logic             vsync,
   output logic             hsync,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] line_y,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   wdec_state_e      state_q, state_d;
   logic             hunt_esc_q, hunt_esc_d;
   logic             first_line_q, first_line_d;
   logic [CNT_W-1:0] next_x_q, next_x_d;
   logic [CNT_W-1:0] pix_x_q, pix_x_d;
   logic [CNT_W-1:0] line_y_q, line_y_d;
   logic [7:0]       dout_q, dout_d;
   logic             pvalid_q, pvalid_d;
   logic             vsync_q, vsync_d;
   logic             hsync_q, hsync_d;
   logic             err_q, err_d;

   logic             xfer;
   logic             emit;
   logic             frame_start;
   logic             line_start;
   logic [7:0]       pix_val;

`ifdef WDEC_RLE_EN
   logic run_load;
   logic run_dec;
   logic run_done;

   wdec_run_ctr u_run_ctr (
      .clk_i      (dclk),
      .rst_i      (rst),
      .load_i     (run_load),
      .load_val_i (din),
      .dec_i      (run_dec),
      .done_o     (run_done)
   );

   assign din_ready = (state_q != ST_REPEAT);
`else
   assign din_ready = 1'b1;
`endif

   assign xfer = din_valid && din_ready;

   always_comb begin
      state_d      = state_q;
      hunt_esc_d   = hunt_esc_q;
      first_line_d = first_line_q;
      next_x_d     = next_x_q;
      pix_x_d      = pix_x_q;
      line_y_d     = line_y_q;
      dout_d       = dout_q;
      pvalid_d     = 1'b0;
      vsync_d      = 1'b0;
      hsync_d      = 1'b0;
      err_d        = 1'b0;
      emit         = 1'b0;
      frame_start  = 1'b0;
      line_start   = 1'b0;
      pix_val      = dout_q;
`ifdef WDEC_RLE_EN
      run_load     = 1'b0;
      run_dec      = 1'b0;
`endif

      case (state_q)
         // Only ESC followed by the frame code leaves HUNT; everything else is dropped.
         ST_HUNT: begin
            if (xfer) begin
               if (hunt_esc_q && (din == CODE_FRAME)) begin
                  frame_start = 1'b1;
               end
               hunt_esc_d = (din == ESC_CODE);
            end
         end
         ST_DATA: begin
            if (xfer) begin
               if (din == ESC_CODE) begin
                  state_d = ST_ESC;
               end else begin
                  emit    = 1'b1;
                  pix_val = din;
               end
            end
         end
         ST_ESC: begin
            if (xfer) begin
               case (din)
                  CODE_LIT_ESC: begin
                     emit    = 1'b1;
                     pix_val = ESC_CODE;
                     state_d = ST_DATA;
                  end
                  CODE_FRAME: frame_start = 1'b1;
                  CODE_LINE: begin
                     line_start = 1'b1;
                     state_d    = ST_DATA;
                  end
`ifdef WDEC_RLE_EN
                  CODE_RUN: state_d = ST_RUNLEN;
`endif
                  default: begin
                     err_d      = 1'b1;
                     hunt_esc_d = 1'b0;
                     state_d    = ST_HUNT;
                  end
               endcase
            end
         end
`ifdef WDEC_RLE_EN
         ST_RUNLEN: begin
            if (xfer) begin
               if (din == 8'd0) begin
                  state_d = ST_DATA;
               end else begin
                  run_load = 1'b1;
                  state_d  = ST_REPEAT;
               end
            end
         end
         ST_REPEAT: begin
            emit    = 1'b1;
            run_dec = 1'b1;
            if (run_done) begin
               state_d = ST_DATA;
            end
         end
`endif
         default: state_d = ST_HUNT;
      endcase

      if (frame_start) begin
         state_d      = ST_DATA;
         hunt_esc_d   = 1'b0;
         vsync_d      = 1'b1;
         first_line_d = 1'b1;
         pix_x_d      = '0;
         next_x_d     = '0;
         line_y_d     = '0;
         dout_d       = 8'h00;
      end

      // The first line start after a frame start keeps line_y at zero.
      if (line_start) begin
         hsync_d      = 1'b1;
         first_line_d = 1'b0;
         if (!first_line_q) begin
            line_y_d = line_y_q + CNT_ONE;
         end
         pix_x_d  = '0;
         next_x_d = '0;
         dout_d   = 8'h00;
      end

      if (emit) begin
         pvalid_d = 1'b1;
         dout_d   = pix_val;
         pix_x_d  = next_x_q;
         next_x_d = next_x_q + CNT_ONE;
      end
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_HUNT;
         hunt_esc_q   <= 1'b0;
         first_line_q <= 1'b0;
         next_x_q     <= '0;
         pix_x_q      <= '0;
         line_y_q     <= '0;
         dout_q       <= 8'h00;
         pvalid_q     <= 1'b0;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hunt_esc_q   <= hunt_esc_d;
         first_line_q <= first_line_d;
         next_x_q     <= next_x_d;
         pix_x_q      <= pix_x_d;
         line_y_q     <= line_y_d;
         dout_q       <= dout_d;
         pvalid_q     <= pvalid_d;
         vsync_q      <= vsync_d;
         hsync_q      <= hsync_d;
         err_q        <= err_d;
      end
   end

   assign dout   = dout_q;
   assign pvalid = pvalid_q;
   assign vsync  = vsync_q;
   assign hsync  = hsync_q;
   assign pix_x  = pix_x_q;
   assign line_y = line_y_q;
   assign err    = err_q;

endmodule

// File: tb/tb_wdecoder.sv
// Directed self-checking bench for wdecoder; repeat-token scenarios run when WDEC_RLE_EN is defined.
module tb_wdecoder;

   logic       dclk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [7:0] dout;
   logic       pvalid, vsync, hsync, err;
   logic [7:0] pix_x, line_y;

   int vec_cnt = 0;
   int err_cnt = 0;

   wdecoder dut (
      .dclk      (dclk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (dout),
      .pvalid    (pvalid),
      .vsync     (vsync),
      .hsync     (hsync),
      .pix_x     (pix_x),
      .line_y    (line_y),
      .err       (err)
   );

   always #5 dclk = ~dclk;

   // Present one input for one clock, then leave the bench 1 time unit past the edge.
   task automatic step(input logic v, input logic [7:0] b);
      din_valid = v;
      din       = b;
      @(posedge dclk);
      #1;
   endtask

   task automatic do_reset();
      din_valid = 1'b0;
      rst = 1'b1;
      @(posedge dclk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      repeat (2) @(posedge dclk);
      #1;
      vec_cnt++; if ({dout, pvalid, vsync, hsync, err} !== 12'h000) begin err_cnt++; $display("FAIL reset_outs got=%h want=000", {dout, pvalid, vsync, hsync, err}); end
      vec_cnt++; if ({pix_x, line_y} !== 16'h0000) begin err_cnt++; $display("FAIL reset_pos got=%h want=0000", {pix_x, line_y}); end
      vec_cnt++; if (din_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got=%b want=1", din_ready); end
      rst = 1'b0;
   endtask

   task automatic test_frame_start();
      do_reset();
      step(1'b1, 8'h05);
      vec_cnt++; if ({pvalid, vsync} !== 2'b00) begin err_cnt++; $display("FAIL hunt_drop got=%b want=00", {pvalid, vsync}); end
      step(1'b1, 8'hFF);
      step(1'b1, 8'h01);
      vec_cnt++; if ({vsync, pvalid, pix_x, line_y} !== 18'h20000) begin err_cnt++; $display("FAIL frame_vsync got=%h want=20000", {vsync, pvalid, pix_x, line_y}); end
      step(1'b1, 8'h01);
      vec_cnt++; if ({pvalid, vsync, dout, pix_x} !== {2'b10, 8'h01, 8'h00}) begin err_cnt++; $display("FAIL frame_pix0 got=%h want=%h", {pvalid, vsync, dout, pix_x}, {2'b10, 8'h01, 8'h00}); end
      step(1'b1, 8'h02);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h02, 8'h01}) begin err_cnt++; $display("FAIL frame_pix1 got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'h02, 8'h01}); end
      step(1'b0, 8'h33);
      vec_cnt++; if ({pvalid, dout} !== {1'b0, 8'h02}) begin err_cnt++; $display("FAIL idle_hold got=%h want=%h", {pvalid, dout}, {1'b0, 8'h02}); end
   endtask

   task automatic test_lines();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01); step(1'b1, 8'hFF);
      step(1'b1, 8'h02);
      vec_cnt++; if ({hsync, pvalid, line_y, pix_x} !== 18'h20000) begin err_cnt++; $display("FAIL line0_hsync got=%h want=20000", {hsync, pvalid, line_y, pix_x}); end
      step(1'b1, 8'h07);
      vec_cnt++; if ({pvalid, hsync, dout, line_y, pix_x} !== {2'b10, 8'h07, 8'h00, 8'h00}) begin err_cnt++; $display("FAIL line0_pix got=%h want=%h", {pvalid, hsync, dout, line_y, pix_x}, {2'b10, 8'h07, 8'h00, 8'h00}); end
      step(1'b1, 8'hFF);
      step(1'b1, 8'h02);
      vec_cnt++; if ({hsync, dout, line_y, pix_x} !== {1'b1, 8'h00, 8'h01, 8'h00}) begin err_cnt++; $display("FAIL line1_hsync got=%h want=%h", {hsync, dout, line_y, pix_x}, {1'b1, 8'h00, 8'h01, 8'h00}); end
      step(1'b1, 8'h08);
      vec_cnt++; if ({pvalid, dout, line_y, pix_x} !== {1'b1, 8'h08, 8'h01, 8'h00}) begin err_cnt++; $display("FAIL line1_pix got=%h want=%h", {pvalid, dout, line_y, pix_x}, {1'b1, 8'h08, 8'h01, 8'h00}); end
   endtask

   task automatic test_lit_esc();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01); step(1'b1, 8'hFF);
      vec_cnt++; if (pvalid !== 1'b0) begin err_cnt++; $display("FAIL esc_prefix pvalid got=%b want=0", pvalid); end
      step(1'b1, 8'h00);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'hFF, 8'h00}) begin err_cnt++; $display("FAIL lit_esc got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'hFF, 8'h00}); end
   endtask

   task automatic test_err();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h7E);
      vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL hunt_noerr got=%b want=0", err); end
      step(1'b1, 8'hFF); step(1'b1, 8'h01); step(1'b1, 8'hFF);
      step(1'b1, 8'h7E);
      vec_cnt++; if ({err, pvalid} !== 2'b10) begin err_cnt++; $display("FAIL bad_code_err got=%b want=10", {err, pvalid}); end
      step(1'b1, 8'h03);
      vec_cnt++; if ({err, pvalid} !== 2'b00) begin err_cnt++; $display("FAIL err_pulse_hunt got=%b want=00", {err, pvalid}); end
      step(1'b1, 8'h44);
      vec_cnt++; if (pvalid !== 1'b0) begin err_cnt++; $display("FAIL hunt_after_err got=%b want=0", pvalid); end
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      vec_cnt++; if (vsync !== 1'b1) begin err_cnt++; $display("FAIL err_recover got=%b want=1", vsync); end
`ifndef WDEC_RLE_EN
      step(1'b1, 8'hFF);
      step(1'b1, 8'h03);
      vec_cnt++; if ({err, pvalid} !== 2'b10) begin err_cnt++; $display("FAIL run_disabled_err got=%b want=10", {err, pvalid}); end
      step(1'b1, 8'h04);
      vec_cnt++; if ({err, pvalid} !== 2'b00) begin err_cnt++; $display("FAIL run_disabled_hunt got=%b want=00", {err, pvalid}); end
`endif
   endtask

   task automatic test_restart_and_gap();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      step(1'b1, 8'h11); step(1'b1, 8'h12);
      step(1'b0, 8'h13);
      vec_cnt++; if (pvalid !== 1'b0) begin err_cnt++; $display("FAIL valid_gap got=%b want=0", pvalid); end
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      vec_cnt++; if ({vsync, err, dout, pix_x} !== {2'b10, 8'h00, 8'h00}) begin err_cnt++; $display("FAIL restart_vsync got=%h want=%h", {vsync, err, dout, pix_x}, {2'b10, 8'h00, 8'h00}); end
      step(1'b1, 8'h22);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h22, 8'h00}) begin err_cnt++; $display("FAIL restart_pix got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'h22, 8'h00}); end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      for (int k = 0; k < 256; k++) step(1'b1, 8'h10);
      vec_cnt++; if ({pvalid, pix_x} !== {1'b1, 8'hFF}) begin err_cnt++; $display("FAIL wrap_last got=%h want=%h", {pvalid, pix_x}, {1'b1, 8'hFF}); end
      step(1'b1, 8'h20);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h20, 8'h00}) begin err_cnt++; $display("FAIL wrap_zero got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'h20, 8'h00}); end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      step(1'b1, 8'h31); step(1'b1, 8'h32);
      #3 rst = 1'b1;
      #1;
      vec_cnt++; if ({pvalid, dout, pix_x} !== 17'h0) begin err_cnt++; $display("FAIL async_rst got=%h want=0", {pvalid, dout, pix_x}); end
      @(posedge dclk); #1;
      rst = 1'b0;
      step(1'b1, 8'h33);
      vec_cnt++; if (pvalid !== 1'b0) begin err_cnt++; $display("FAIL async_rst_hunt got=%b want=0", pvalid); end
   endtask

`ifdef WDEC_RLE_EN
   task automatic test_repeat();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      step(1'b1, 8'h09);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h09, 8'h00}) begin err_cnt++; $display("FAIL rep_seed got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'h09, 8'h00}); end
      step(1'b1, 8'hFF); step(1'b1, 8'h03);
      step(1'b1, 8'h04);
      vec_cnt++; if ({din_ready, pvalid} !== 2'b00) begin err_cnt++; $display("FAIL rep_count_byte got=%b want=00", {din_ready, pvalid}); end
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 8'h55);
         vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h09, 8'(i)}) begin err_cnt++; $display("FAIL rep_pix%0d got=%h want=%h", i, {pvalid, dout, pix_x}, {1'b1, 8'h09, 8'(i)}); end
         vec_cnt++; if (din_ready !== (i == 4)) begin err_cnt++; $display("FAIL rep_ready%0d got=%b want=%b", i, din_ready, (i == 4)); end
      end
      step(1'b1, 8'h55);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h55, 8'h05}) begin err_cnt++; $display("FAIL rep_next got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'h55, 8'h05}); end
      step(1'b1, 8'hFF); step(1'b1, 8'h03);
      step(1'b1, 8'h00);
      vec_cnt++; if ({pvalid, din_ready} !== 2'b01) begin err_cnt++; $display("FAIL rep_zero got=%b want=01", {pvalid, din_ready}); end
      step(1'b1, 8'h0A);
      vec_cnt++; if ({pvalid, dout, pix_x} !== {1'b1, 8'h0A, 8'h06}) begin err_cnt++; $display("FAIL rep_zero_next got=%h want=%h", {pvalid, dout, pix_x}, {1'b1, 8'h0A, 8'h06}); end
   endtask

   task automatic test_repeat_reset();
      do_reset();
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      step(1'b1, 8'h09); step(1'b1, 8'hFF); step(1'b1, 8'h03);
      step(1'b1, 8'h10);
      step(1'b0, 8'h00); step(1'b0, 8'h00);
      vec_cnt++; if ({pvalid, din_ready} !== 2'b10) begin err_cnt++; $display("FAIL rep_mid got=%b want=10", {pvalid, din_ready}); end
      #3 rst = 1'b1;
      #1;
      vec_cnt++; if ({pvalid, din_ready, dout} !== {2'b01, 8'h00}) begin err_cnt++; $display("FAIL rep_abort got=%h want=%h", {pvalid, din_ready, dout}, {2'b01, 8'h00}); end
      @(posedge dclk); #1;
      rst = 1'b0;
      step(1'b1, 8'h33);
      vec_cnt++; if (pvalid !== 1'b0) begin err_cnt++; $display("FAIL rep_abort_hunt got=%b want=0", pvalid); end
      step(1'b1, 8'hFF); step(1'b1, 8'h01);
      vec_cnt++; if (vsync !== 1'b1) begin err_cnt++; $display("FAIL rep_abort_frame got=%b want=1", vsync); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame_start();
      test_lines();
      test_lit_esc();
      test_err();
      test_restart_and_gap();
      test_wrap();
      test_async_reset();
`ifdef WDEC_RLE_EN
      test_repeat();
      test_repeat_reset();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
